ifetch_queue: RTL

- Instruction-fetch front end that consumes the program counter.
- Holds its own fetch PC, starting at 0x0000_3000.
- Issues word reads to instruction memory over a req/gnt/rvalid handshake and buffers the returned words with their PCs in a small FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Branch/jump redirects flush the queue and restart fetch.

---
 rtl/ifetch_queue_pkg.sv | 6 +
 rtl/ifetch_queue_if.sv | 23 ++
 rtl/ifetch_queue_fifo.sv | 49 ++++
 rtl/ifetch_queue.sv | 76 +++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared fetch constants and fetch FSM state encoding
package ifetch_queue_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int INST_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction memory, redirect and decode handshake bundle
interface ifetch_queue_if;
    import ifetch_queue_pkg::*;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redir_valid;
    logic [31:0]       redir_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              inst_ready;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redir_valid, redir_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redir_valid, redir_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifetch_queue_fifo: small synchronous FIFO with flush holding fetched {pc, inst} pairs
module ifetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic [W-1:0]   i_data,
    output logic [PTR_W:0] o_count,
    output logic [W-1:0]   o_head
);
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [W-1:0]     r_mem [DEPTH];

    // pointer and occupancy bookkeeping; flush wins over a same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
        end
    end

    // storage is cleared on reset so the head reads zero before the first push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch FSM issuing one outstanding imem read at a time into a PC/instruction FIFO
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = ifetch_queue_pkg::RESET_PC,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            rst,
    ifetch_queue_if.master bus
);
    import ifetch_queue_pkg::*;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    fetch_state_t           r_state;
    fetch_state_t           w_state_nxt;
    logic [31:0]            r_fetch_pc;
    logic [31:0]            w_fetch_pc_nxt;
    logic                   w_req;
    logic                   w_push;
    logic                   w_pop;
    logic [PTR_W:0]         w_count;
    logic [32+INST_W-1:0]   w_head;

    // next state, request and push decode; a redirect turns any read in flight into a drop
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                w_req = (w_count < FULL);
                if (w_req && bus.imem_gnt) w_state_nxt = bus.redir_valid ? DROP : WAIT;
            end
            WAIT: begin
                w_push      = bus.imem_rvalid && !bus.redir_valid;
                w_state_nxt = bus.imem_rvalid ? REQ : (bus.redir_valid ? DROP : WAIT);
            end
            DROP: w_state_nxt = bus.imem_rvalid ? REQ : DROP;
            default: w_state_nxt = IDLE;
        endcase
        w_fetch_pc_nxt = bus.redir_valid ? (bus.redir_pc & ~32'd3) :
                         w_push ? r_fetch_pc + 32'd4 : r_fetch_pc;
    end

    // fetch FSM state and fetch PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    assign w_pop = (w_count != '0) && bus.inst_ready;

    ifetch_queue_fifo #(.DEPTH(DEPTH), .W(32 + INST_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redir_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_fetch_pc, bus.imem_rdata}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = {r_fetch_pc[31:2], 2'b00};
    assign bus.inst_valid = (w_count != '0);
    assign bus.inst       = w_head[INST_W-1:0];
    assign bus.inst_pc    = w_head[32+INST_W-1:INST_W];
endmodule
